reg_b_addr_sel_pipe: RTL

//   Read-port-B register-address selector for the datapath decode stage. Generalises the 2:1
//   Rn_2 select to NUM_SRC address sources of ADDR_W bits, with a registered output, a

---
 rtl/reg_b_addr_sel_pipe_pkg.sv | 22 ++
 rtl/reg_b_addr_sel_pipe_mux_n.sv | 26 ++
 rtl/reg_b_addr_sel_pipe.sv | 84 ++++++++
 3 files changed

// File: rtl/reg_b_addr_sel_pipe_pkg.sv
// Shared datapath definitions for register-address handling in decode and the register file.
// Also holds the stage-control priority used by the read-port-B address pipeline.
package reg_b_addr_sel_pipe_pkg;

  localparam int REG_ADDR_W  = 4;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;
  localparam int DEF_NUM_SRC = 2;

  typedef enum logic [1:0] {
    STAGE_LOAD  = 2'd0,
    STAGE_STALL = 2'd1,
    STAGE_FLUSH = 2'd2
  } stage_op_e;

  // Flush dominates stall, stall dominates load.
  function automatic stage_op_e stage_op(input logic flush, input logic stall);
    if (flush) return STAGE_FLUSH;
    if (stall) return STAGE_STALL;
    return STAGE_LOAD;
  endfunction

endpackage

// File: rtl/reg_b_addr_sel_pipe_mux_n.sv
// NUM_SRC:1 register-address multiplexer; an out-of-range select falls back to source 0
// and raises oob_o so the stage can record the error.
module reg_b_addr_sel_pipe_mux_n
  import reg_b_addr_sel_pipe_pkg::*;
#(
  parameter int ADDR_W  = REG_ADDR_W,
  parameter int NUM_SRC = DEF_NUM_SRC,
  parameter int SEL_W   = 1
) (
  input  logic [NUM_SRC*ADDR_W-1:0] src_i,
  input  logic [SEL_W-1:0]          sel_i,
  output logic [ADDR_W-1:0]         addr_o,
  output logic                      oob_o
);

  // NOTE: every always_comb output gets a default first; a path with no assignment infers a latch.
  always_comb begin
    addr_o = src_i[ADDR_W-1:0];
    for (int k = 1; k < NUM_SRC; k++) begin
      if (int'(sel_i) == k) addr_o = src_i[k*ADDR_W +: ADDR_W];
    end
  end

  assign oob_o = (int'(sel_i) >= NUM_SRC);

endmodule

// File: rtl/reg_b_addr_sel_pipe.sv
// Read-port-B register-address selector: registered NUM_SRC:1 select with stall/flush,
// sticky out-of-range flag and a write-back forwarding-hit compare.
module reg_b_addr_sel_pipe
  import reg_b_addr_sel_pipe_pkg::*;
#(
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int NUM_SRC  = DEF_NUM_SRC,
  parameter int SEL_W    = 1,
  parameter int ZERO_FWD = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC*ADDR_W-1:0] in_addr,
  input  logic [SEL_W-1:0]          regB,
  input  logic                      in_valid,
  input  logic                      stall,
  input  logic                      flush,
  input  logic                      wb_en,
  input  logic [ADDR_W-1:0]         wb_addr,
  output logic [ADDR_W-1:0]         rn2,
  output logic                      rn2_valid,
  output logic                      fwd_hit,
  output logic                      sel_err
);

  if (NUM_SRC < 2 || (2 ** SEL_W) < NUM_SRC) begin : g_bad_params
    $error("reg_b_addr_sel_pipe: need NUM_SRC>=2 and 2**SEL_W>=NUM_SRC");
  end

  logic [ADDR_W-1:0] mux_addr;
  logic              mux_oob;

  logic [ADDR_W-1:0] rn2_q, rn2_d;
  logic              rn2_valid_q, rn2_valid_d;
  logic              sel_err_q, sel_err_d;

  reg_b_addr_sel_pipe_mux_n #(
    .ADDR_W (ADDR_W),
    .NUM_SRC(NUM_SRC),
    .SEL_W  (SEL_W)
  ) u_mux (
    .src_i (in_addr),
    .sel_i (regB),
    .addr_o(mux_addr),
    .oob_o (mux_oob)
  );

  always_comb begin
    rn2_d       = rn2_q;
    rn2_valid_d = rn2_valid_q;
    sel_err_d   = sel_err_q;
    case (stage_op(flush, stall))
      STAGE_FLUSH: rn2_valid_d = 1'b0;
      STAGE_STALL: ;
      default: begin
        rn2_d       = mux_addr;
        rn2_valid_d = in_valid;
        if (in_valid && mux_oob) sel_err_d = 1'b1;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rn2_q       <= '0;
      rn2_valid_q <= 1'b0;
      sel_err_q   <= 1'b0;
    end else begin
      rn2_q       <= rn2_d;
      rn2_valid_q <= rn2_valid_d;
      sel_err_q   <= sel_err_d;
    end
  end

  // Live write-back inputs are compared against the held address, so this tracks wb even while stalled.
  assign fwd_hit = rn2_valid_q && wb_en && (wb_addr == rn2_q) &&
                   ((ZERO_FWD != 0) || (rn2_q != ADDR_W'(REG_ZERO)));

  assign rn2       = rn2_q;
  assign rn2_valid = rn2_valid_q;
  assign sel_err   = sel_err_q;

endmodule
